mul_addtree_pipe: RTL and testbench
===================================

Name: mul_addtree_pipe

Overview:
Parametrised N x N multiplier built as a pipelined shift-and-add tree, with one registered adder level per tree stage. It supports unsigned and two's-complement operands, selected per transaction. A valid/ready handshake with back-pressure lets it sit between streaming datapath blocks and on-chip RAM/FIFO buffers. A synchronous flush drops all in-flight products.

Parameters:
WIDTH, 4, operand width in bits; legal range 2..16; need not be a power of 2.
LEVELS, $clog2(WIDTH), number of registered adder levels (derived; not overridden); equals pipeline latency.

Ports:
clk  input  1  clock, rising edge
clr  input  1  asynchronous active-low reset
flush  input  1  synchronous; invalidates all pipeline stages
in_valid  input  1  operands present
in_ready  output  1  block accepts operands this cycle
in_signed  input  1  1 = both operands two's complement, 0 = unsigned
mul_a  input  WIDTH  multiplicand
mul_b  input  WIDTH  multiplier
out_valid  output  1  mul_out holds a product
out_ready  input  1  downstream accepts product
mul_out  output  2*WIDTH  product

Behaviour:
- Reset (clr low, async): all stage valid bits 0, all stage data registers 0, mul_out = 0, out_valid = 0. in_ready = 1 after reset.
- Partial products are combinational from the input operands. pp[i] = mul_b[i] ? ext(mul_a) << i : 0, computed in 2*WIDTH bits.
  - ext() is a sign extension when in_signed = 1 and a zero extension otherwise.
  - When in_signed = 1, pp[WIDTH-1] is negated (two's complement, mod 2^(2*WIDTH)).
- Partial products are zero-padded up to P = 2^LEVELS entries.
- Level k (k = 1..LEVELS) pairwise-adds the outputs of level k-1 and registers them. Level k holds P/2^k sums.
- All sums are 2*WIDTH bits and wrap mod 2^(2*WIDTH). Overflow is impossible for legal operands.
- The final level register is mul_out.
- Latency: a product accepted at rising edge t appears with out_valid = 1 after edge t+LEVELS-1, i.e. it is visible during cycle t+LEVELS. With WIDTH=4, LEVELS=2, which gives 2-cycle latency.
- Each level carries a valid bit alongside its data.
- Advance enable: adv = !out_valid || out_ready. The whole pipe shifts only when adv = 1 (global stall, no bubble collapsing).
- in_ready = adv. An operand is accepted when in_valid && in_ready. A bubble (valid 0) enters when in_valid = 0 and adv = 1.
- While adv = 0, every stage's data and valid bits hold, and mul_out stays stable while out_valid = 1.
- Throughput is 1 product per cycle when out_ready stays high.
- flush = 1 at a rising edge clears all valid bits, and also clears out_valid, regardless of adv. No input is accepted that cycle: in_ready is forced to 0 while flush = 1. Data registers may retain stale values.
- Reset mid-operation: all in-flight products are lost and nothing is emitted for them afterwards.
- in_signed travels with the operands. Mixing signed and unsigned transactions back-to-back is legal.

Decomposition:
- Package mul_pkg holds:
  - constant MAX_WIDTH = 16;
  - function clog2_f for elaboration;
  - typedef-free width helper PROD_W(w) = 2*w.
- One sub-module, mul_tree_level, parametrised on input count N and data width DW. It contains N/2 registered adders, a valid flop, and adv/flush/clr inputs.
- The top instantiates LEVELS copies of mul_tree_level via generate, plus the combinational partial-product logic.

Test Plan:
- WIDTH=4, unsigned, a=3, b=5, out_ready=1 -> mul_out=8'h0F with out_valid high exactly 2 cycles after acceptance. Then 15x15 -> 8'hE1.
- WIDTH=4, in_signed=1: -1x-1 (4'hF, 4'hF) -> 8'h01; -8x7 (4'h8, 4'h7) -> 8'hC8; -8x-8 -> 8'h40. Signed/unsigned interleaved each cycle, with 4'hF x 4'hF unsigned next -> 8'hE1.
- Streaming 16 back-to-back pairs (a=i, b=i+1) with out_ready toggled 1,0,0,1: no product lost or duplicated; mul_out holds while stalled; in_ready low exactly when out_valid && !out_ready.
- Reset mid-operation: clr pulsed low with 2 products in flight -> mul_out=0, out_valid=0 immediately (async), and no output for the dropped products after clr rises.
- flush asserted with the pipe full -> out_valid=0 next cycle, in_ready=0 during the flush cycle; the next accepted 2x3 yields 8'h06 after 2 cycles.
- WIDTH=5 (non-power-of-2, LEVELS=3): unsigned 31x31 -> 10'h3C1 (961) after 3 cycles; signed -16x-16 -> 10'h100.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared constants and elaboration helpers for the pipelined add-tree multiplier.
// Everything here is constant-evaluable so it can size ports and generate loops.
package mul_pkg;

    localparam int unsigned MAX_WIDTH = 16;

    function automatic int unsigned clog2_f(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic int unsigned prod_w(input int unsigned w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/mul_addtree_pipe_if.sv
// Operand/product streaming interface for mul_addtree_pipe.
// The master drives operands and consumes products; the slave is the multiplier.
interface mul_addtree_pipe_if #(
    parameter int unsigned WIDTH = 4
);
    import mul_pkg::*;

    logic                       in_valid;
    logic                       in_ready;
    logic                       in_signed;
    logic [WIDTH-1:0]           mul_a;
    logic [WIDTH-1:0]           mul_b;
    logic                       out_valid;
    logic                       out_ready;
    logic [prod_w(WIDTH)-1:0]   mul_out;

    modport master (
        output in_valid, in_signed, mul_a, mul_b, out_ready,
        input  in_ready, out_valid, mul_out
    );

    modport slave (
        input  in_valid, in_signed, mul_a, mul_b, out_ready,
        output in_ready, out_valid, mul_out
    );

endinterface

// File: rtl/mul_tree_level.sv
// One registered level of the add tree: N inputs reduced pairwise to N/2 sums,
// plus the valid bit that travels alongside them.
module mul_tree_level #(
    parameter int unsigned N  = 2,
    parameter int unsigned DW = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  flush_i,
    input  logic                  adv_i,
    input  logic                  valid_i,
    input  logic [N-1:0][DW-1:0]  data_i,
    output logic                  valid_o,
    output logic [N/2-1:0][DW-1:0] data_o
);

    logic                   valid_d, valid_q;
    logic [N/2-1:0][DW-1:0] sum_d, sum_q;

    // Flush only kills the valid bit; stale data is harmless once invalid.
    always_comb begin
        valid_d = valid_q;
        sum_d   = sum_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (adv_i) begin
            valid_d = valid_i;
            for (int j = 0; j < N / 2; j++) begin
                sum_d[j] = data_i[2*j] + data_i[2*j+1];
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
        end else begin
            valid_q <= valid_d;
            sum_q   <= sum_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = sum_q;

endmodule

// File: rtl/mul_addtree_pipe.sv
// Pipelined N x N shift-and-add multiplier, unsigned or two's complement per
// transaction, with a global-stall valid/ready pipe and a synchronous flush.
module mul_addtree_pipe #(
    parameter int unsigned WIDTH = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              flush,
    mul_addtree_pipe_if.slave mul_io
);
    import mul_pkg::*;

    localparam int unsigned LEVELS = clog2_f(WIDTH);
    localparam int unsigned P      = 1 << LEVELS;
    localparam int unsigned PW     = prod_w(WIDTH);

    logic                 adv;
    logic [PW-1:0]        ext_a;
    logic [P-1:0][PW-1:0] pp;

    assign adv             = !mul_io.out_valid || mul_io.out_ready;
    assign mul_io.in_ready = adv && !flush;

    // The MSB of a signed multiplier carries weight -2^(WIDTH-1), hence the negation.
    always_comb begin
        ext_a = mul_io.in_signed ? {{WIDTH{mul_io.mul_a[WIDTH-1]}}, mul_io.mul_a}
                                 : {{WIDTH{1'b0}}, mul_io.mul_a};
        pp    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mul_io.mul_b[i]) begin
                pp[i] = ext_a << i;
                if (mul_io.in_signed && (i == WIDTH - 1)) begin
                    pp[i] = -pp[i];
                end
            end
        end
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int unsigned N = P >> k;

        logic [N-1:0][PW-1:0]   din;
        logic                   vin;
        logic [N/2-1:0][PW-1:0] sum;
        logic                   vld;

        if (k == 0) begin : g_first
            assign din = pp;
            assign vin = mul_io.in_valid;
        end else begin : g_next
            assign din = g_lvl[k-1].sum;
            assign vin = g_lvl[k-1].vld;
        end

        mul_tree_level #(
            .N  (N),
            .DW (PW)
        ) u_level (
            .clk     (clk),
            .clr     (clr),
            .flush_i (flush),
            .adv_i   (adv),
            .valid_i (vin),
            .data_i  (din),
            .valid_o (vld),
            .data_o  (sum)
        );
    end

    assign mul_io.out_valid = g_lvl[LEVELS-1].vld;
    assign mul_io.mul_out   = g_lvl[LEVELS-1].sum[0];

endmodule

// File: tb/tb_mul_addtree_pipe.sv
// Directed bench for mul_addtree_pipe: a WIDTH=4 instance for the main checks
// and a WIDTH=5 instance for the non-power-of-two tree depth.
module tb_mul_addtree_pipe;

    logic clk = 1'b0;
    logic clr;
    logic flush4;
    logic flush5;

    always #5 clk = ~clk;

    mul_addtree_pipe_if #(.WIDTH(4)) bus4 ();
    mul_addtree_pipe_if #(.WIDTH(5)) bus5 ();

    mul_addtree_pipe #(.WIDTH(4)) dut4 (
        .clk    (clk),
        .clr    (clr),
        .flush  (flush4),
        .mul_io (bus4)
    );

    mul_addtree_pipe #(.WIDTH(5)) dut5 (
        .clk    (clk),
        .clr    (clr),
        .flush  (flush5),
        .mul_io (bus5)
    );

    typedef struct {
        logic       sgn;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[12];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic v, input logic s, input logic [3:0] a, input logic [3:0] b);
        bus4.in_valid  = v;
        bus4.in_signed = s;
        bus4.mul_a     = a;
        bus4.mul_b     = b;
    endtask

    task automatic run5(input string nm, input logic s, input logic [4:0] a,
                        input logic [4:0] b, input logic [9:0] exp);
        bus5.in_signed = s;
        bus5.mul_a     = a;
        bus5.mul_b     = b;
        bus5.in_valid  = 1'b1;
        tick();
        bus5.in_valid = 1'b0;
        tick();
        check({nm, "_early"}, 32'(bus5.out_valid), 32'd0);
        tick();
        check({nm, "_valid"}, 32'(bus5.out_valid), 32'd1);
        check({nm, "_data"}, 32'(bus5.mul_out), 32'(exp));
    endtask

    logic [7:0] sq[$];
    logic [7:0] held;
    bit         hold;
    int         sent;
    int         recv;
    int         cyc;
    logic [3:0] pat;

    initial begin
        vecs[0]  = '{1'b0, 4'h3, 4'h5, 8'h0F};
        vecs[1]  = '{1'b1, 4'hF, 4'hF, 8'h01};
        vecs[2]  = '{1'b0, 4'hF, 4'hF, 8'hE1};
        vecs[3]  = '{1'b1, 4'h8, 4'h7, 8'hC8};
        vecs[4]  = '{1'b0, 4'h8, 4'h7, 8'h38};
        vecs[5]  = '{1'b1, 4'h8, 4'h8, 8'h40};
        vecs[6]  = '{1'b0, 4'hF, 4'hF, 8'hE1};
        vecs[7]  = '{1'b1, 4'h7, 4'h7, 8'h31};
        vecs[8]  = '{1'b0, 4'h9, 4'hA, 8'h5A};
        vecs[9]  = '{1'b1, 4'h5, 4'hF, 8'hFB};
        vecs[10] = '{1'b0, 4'h0, 4'h9, 8'h00};
        vecs[11] = '{1'b1, 4'hF, 4'h8, 8'h08};

        clr    = 1'b0;
        flush4 = 1'b0;
        flush5 = 1'b0;
        drive4(1'b0, 1'b0, 4'h0, 4'h0);
        bus4.out_ready = 1'b1;
        bus5.in_valid  = 1'b0;
        bus5.in_signed = 1'b0;
        bus5.mul_a     = '0;
        bus5.mul_b     = '0;
        bus5.out_ready = 1'b1;

        #2;
        check("rst_mul_out", 32'(bus4.mul_out), 32'd0);
        check("rst_out_valid", 32'(bus4.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus4.in_ready), 32'd1);
        check("rst_out_valid5", 32'(bus5.out_valid), 32'd0);
        #10 clr = 1'b1;
        tick();

        // Exact latency: accepted at edge t, visible after edge t+1.
        drive4(1'b1, 1'b0, 4'h3, 4'h5);
        tick();
        drive4(1'b0, 1'b0, 4'h0, 4'h0);
        check("lat_early", 32'(bus4.out_valid), 32'd0);
        tick();
        check("lat_valid", 32'(bus4.out_valid), 32'd1);
        check("lat_data", 32'(bus4.mul_out), 32'h0F);
        tick();
        check("lat_after", 32'(bus4.out_valid), 32'd0);

        // Back-to-back table, signed and unsigned alternating.
        for (int c = 0; c <= 12; c++) begin
            if (c < 12) drive4(1'b1, vecs[c].sgn, vecs[c].a, vecs[c].b);
            else        drive4(1'b0, 1'b0, 4'h0, 4'h0);
            tick();
            if (c >= 1) begin
                check($sformatf("vec%0d_valid", c - 1), 32'(bus4.out_valid), 32'd1);
                check($sformatf("vec%0d_data", c - 1), 32'(bus4.mul_out), 32'(vecs[c-1].exp));
            end
        end
        tick();
        check("vec_drain", 32'(bus4.out_valid), 32'd0);

        // Streaming with out_ready pattern 1,0,0,1.
        pat  = 4'b1001;
        sent = 0;
        recv = 0;
        cyc  = 0;
        hold = 1'b0;
        while (recv < 16 && cyc < 200) begin
            bus4.out_ready = pat[cyc%4];
            drive4(sent < 16, 1'b0, 4'(sent), 4'(sent + 1));
            @(negedge clk);
            if (hold) begin
                check("stall_valid", 32'(bus4.out_valid), 32'd1);
                check("stall_hold", 32'(bus4.mul_out), 32'(held));
                hold = 1'b0;
            end
            check("stream_in_ready", 32'(bus4.in_ready),
                  32'(!(bus4.out_valid && !bus4.out_ready)));
            if (bus4.in_valid && bus4.in_ready) begin
                sq.push_back(8'(sent * ((sent + 1) % 16)));
                sent++;
            end
            if (bus4.out_valid && bus4.out_ready) begin
                if (sq.size() == 0) check("stream_extra", 32'(sq.size()), 32'd1);
                else                check("stream_data", 32'(bus4.mul_out), 32'(sq.pop_front()));
                recv++;
            end else if (bus4.out_valid) begin
                held = bus4.mul_out;
                hold = 1'b1;
            end
            tick();
            cyc++;
        end
        check("stream_count", 32'(recv), 32'd16);
        check("stream_left", 32'(sq.size()), 32'd0);
        drive4(1'b0, 1'b0, 4'h0, 4'h0);
        bus4.out_ready = 1'b1;
        check("stream_dup", 32'(bus4.out_valid), 32'd0);

        // Asynchronous reset with two products in flight.
        drive4(1'b1, 1'b0, 4'h2, 4'h2);
        tick();
        drive4(1'b1, 1'b0, 4'h3, 4'h3);
        tick();
        drive4(1'b0, 1'b0, 4'h0, 4'h0);
        check("pre_rst_valid", 32'(bus4.out_valid), 32'd1);
        #1 clr = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus4.out_valid), 32'd0);
        check("mid_rst_data", 32'(bus4.mul_out), 32'd0);
        #2 clr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_quiet", 32'(bus4.out_valid), 32'd0);
        end

        // Flush with the pipe full and stalled.
        bus4.out_ready = 1'b0;
        drive4(1'b1, 1'b0, 4'h4, 4'h4);
        tick();
        drive4(1'b1, 1'b0, 4'h5, 4'h5);
        tick();
        check("pre_flush_valid", 32'(bus4.out_valid), 32'd1);
        flush4 = 1'b1;
        drive4(1'b1, 1'b0, 4'h7, 4'h7);
        #1;
        check("flush_in_ready", 32'(bus4.in_ready), 32'd0);
        tick();
        flush4 = 1'b0;
        drive4(1'b0, 1'b0, 4'h0, 4'h0);
        bus4.out_ready = 1'b1;
        check("flush_out_valid", 32'(bus4.out_valid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("flush_leak", 32'(bus4.out_valid), 32'd0);
        end
        drive4(1'b1, 1'b0, 4'h2, 4'h3);
        tick();
        drive4(1'b0, 1'b0, 4'h0, 4'h0);
        check("post_flush_early", 32'(bus4.out_valid), 32'd0);
        tick();
        check("post_flush_valid", 32'(bus4.out_valid), 32'd1);
        check("post_flush_data", 32'(bus4.mul_out), 32'h06);

        // Five-bit operands, three-level tree.
        run5("w5_u31x31", 1'b0, 5'h1F, 5'h1F, 10'h3C1);
        run5("w5_s16x16", 1'b1, 5'h10, 5'h10, 10'h100);
        run5("w5_s15xm15", 1'b1, 5'h0F, 5'h11, 10'h31F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
